// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared encodings for the counter sequencer
// Purpose: FSM state encoding and run-mode constants shared by the
// sequencer and its testbench.
// Ports: none (package).
package counter_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_ctrl_pkg

// File: rtl/up_counter_core.sv
// rtl/up_counter_core.sv - synchronous up-counter datapath with clear/enable
// Purpose: plain up-counter stepped by the sequencer.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, count to 0
//   clear  - synchronous clear to 0, wins over enable
//   enable - increment by one
//   count  - registered counter value
module up_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : up_counter_core

// File: rtl/counter_sched_ctrl.sv
// rtl/counter_sched_ctrl.sv - prescaled one-shot/periodic counter sequencer
// Purpose: latches terminal value, prescale and mode on start, steps the
// counter every prescale+1 clocks and pulses tick on each terminal wrap.
// One-shot runs end after the first wrap with a done pulse.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start, stop        - control pulses (stop wins when both are high)
//   mode               - 0 one-shot, 1 periodic (sampled at start)
//   target, prescale   - terminal count and divider (sampled at start)
//   busy               - high while running
//   count              - current counter value
//   tick, done         - one-cycle event pulses
module counter_sched_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] target,
    input  logic [PRE_W-1:0] prescale,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done
);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             clear, enable;
    logic             step, at_term;

    up_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .count  (count)
    );

    assign step    = (state_q == ST_RUN) && (presc_q == pre_q);
    assign at_term = (count == target_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            target_q <= '0;
            pre_q    <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            pre_q    <= pre_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // stop dominates start and any step due at the same edge
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
        end else if (step && at_term && (mode_q == MODE_ONESHOT)) begin
            state_d = ST_IDLE;
        end
    end

    // A start (or restart) discards any step due at that edge.
    always_comb begin
        mode_d   = mode_q;
        target_d = target_q;
        pre_d    = pre_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        clear    = 1'b0;
        enable   = 1'b0;
        if (!stop) begin
            if (start) begin
                mode_d   = mode;
                target_d = target;
                pre_d    = prescale;
                presc_d  = '0;
                clear    = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (step) begin
                    presc_d = '0;
                    if (at_term) begin
                        clear  = 1'b1;
                        tick_d = 1'b1;
                        done_d = (mode_q == MODE_ONESHOT);
                    end else begin
                        enable = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign tick = tick_q;
    assign done = done_q;

endmodule : counter_sched_ctrl

// File: tb/tb_counter_sched_ctrl.sv
// tb/tb_counter_sched_ctrl.sv - self-checking bench for counter_sched_ctrl
module tb_counter_sched_ctrl;

    localparam int WIDTH = 4;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             reset, start, stop, mode;
    logic [WIDTH-1:0] target;
    logic [PRE_W-1:0] prescale;
    logic             busy, tick, done;
    logic [WIDTH-1:0] count;

    always #5 clk = ~clk;

    counter_sched_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .target   (target),
        .prescale (prescale),
        .busy     (busy),
        .count    (count),
        .tick     (tick),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: count derived from clocks elapsed since start.
    int m_run, m_mode, m_tgt, m_pre, m_el, m_cnt, m_tick, m_done;

    typedef struct {
        logic       r, st, sp, md;
        logic [3:0] tg, ps;
        logic       b;
        logic [3:0] c;
        logic       t, d;
    } vec_t;

    vec_t tbl[64];
    int   nv = 0;

    task automatic add(input logic r, st, sp, md, input logic [3:0] tg, ps,
                       input logic b, input logic [3:0] c, input logic t, d);
        tbl[nv].r = r;  tbl[nv].st = st; tbl[nv].sp = sp; tbl[nv].md = md;
        tbl[nv].tg = tg; tbl[nv].ps = ps;
        tbl[nv].b = b;  tbl[nv].c = c;  tbl[nv].t = t;  tbl[nv].d = d;
        nv++;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s busy/count/tick/done got %b/%0d/%b/%b want %b/%0d/%b/%b",
                     name, act[6], act[5:2], act[1], act[0], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_step();
        m_tick = 0;
        m_done = 0;
        if (reset) begin
            m_run = 0; m_cnt = 0; m_el = 0;
            m_mode = 0; m_tgt = 0; m_pre = 0;
        end else if (stop) begin
            m_run = 0;
        end else if (start) begin
            m_mode = int'(mode);
            m_tgt  = int'(target);
            m_pre  = int'(prescale);
            m_el   = 0;
            m_cnt  = 0;
            m_run  = 1;
        end else if (m_run != 0) begin
            m_el++;
            if (m_el % (m_pre + 1) == 0) begin
                m_cnt = (m_el / (m_pre + 1)) % (m_tgt + 1);
                if (m_cnt == 0) begin
                    m_tick = 1;
                    if (m_mode == 0) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [6:0] outs();
        return {busy, count, tick, done};
    endfunction

    function automatic logic [6:0] mexp();
        logic [3:0] c;
        c = m_cnt[3:0];
        return {m_run[0], c, m_tick[0], m_done[0]};
    endfunction

    task automatic cyc(input string name, input logic r, st, sp, md,
                       input logic [3:0] tg, ps);
        reset = r; start = st; stop = sp; mode = md; target = tg; prescale = ps;
        @(posedge clk);
        model_step();
        #1;
        check(name, outs(), mexp());
    endtask

    task automatic idle(input string name);
        cyc(name, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h3);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        target = '0; prescale = '0;
        m_run = 0; m_mode = 0; m_tgt = 0; m_pre = 0;
        m_el = 0; m_cnt = 0; m_tick = 0; m_done = 0;

        // reset, idle, one-shot target=3 prescale=0 (config inputs wiggled mid-run)
        add(1,0,0,0, 0,0, 0,0,0,0);
        add(1,0,0,0, 0,0, 0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 0,0, 0,0,0,0);
        add(0,1,0,0, 3,0, 1,0,0,0);
        add(0,0,0,1, 7,2, 1,1,0,0);
        add(0,0,0,1, 7,2, 1,2,0,0);
        add(0,0,0,0, 9,5, 1,3,0,0);
        add(0,0,0,0, 3,0, 0,0,1,1);
        for (int i = 0; i < 10; i++) add(0,0,0,0, 3,0, 0,0,0,0);
        // periodic target=2 prescale=1
        add(0,1,0,1, 2,1, 1,0,0,0);
        for (int k = 0; k < 2; k++) begin
            add(0,0,0,1, 2,1, 1,0,0,0);
            add(0,0,0,1, 2,1, 1,1,0,0);
            add(0,0,0,1, 2,1, 1,1,0,0);
            add(0,0,0,1, 2,1, 1,2,0,0);
            add(0,0,0,1, 2,1, 1,2,0,0);
            add(0,0,0,1, 2,1, 1,0,1,0);
        end

        for (int i = 0; i < nv; i++) begin
            cyc($sformatf("vec%0d_model", i), tbl[i].r, tbl[i].st, tbl[i].sp,
                tbl[i].md, tbl[i].tg, tbl[i].ps);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].b, tbl[i].c, tbl[i].t, tbl[i].d});
        end

        // stop while periodic run sits at count=1
        cyc("stop_start", 0,1,0,1, 2,1);
        for (int i = 0; i < 20 && count != 4'd1; i++) idle("stop_wait");
        check("stop_reach1", {3'b0, count}, 7'd1);
        cyc("stop", 0,0,1,0, 2,1);
        check("stop_frozen", outs(), {1'b0, 4'd1, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) idle("stop_hold");
        check("stop_hold_c", outs(), {1'b0, 4'd1, 1'b0, 1'b0});
        cyc("stop_idle", 0,0,1,0, 2,1);
        cyc("restart", 0,1,0,1, 2,1);
        check("restart_c", outs(), {1'b1, 4'd0, 1'b0, 1'b0});

        // restart in RUN at count=4 with new target=1
        cyc("rs_start", 0,1,0,1, 5,0);
        for (int i = 0; i < 20 && count != 4'd4; i++) idle("rs_wait");
        check("rs_reach4", {3'b0, count}, 7'd4);
        cyc("rs_new", 0,1,0,1, 1,0);
        check("rs_new_c", outs(), {1'b1, 4'd0, 1'b0, 1'b0});
        idle("rs1");
        check("rs1_c", outs(), {1'b1, 4'd1, 1'b0, 1'b0});
        idle("rs2");
        check("rs2_c", outs(), {1'b1, 4'd0, 1'b1, 1'b0});
        idle("rs3");
        idle("rs4");
        check("rs4_c", outs(), {1'b1, 4'd0, 1'b1, 1'b0});
        cyc("rs_stop", 0,0,1,0, 0,0);

        // start+stop together in IDLE
        cyc("ss_idle", 0,1,1,1, 3,0);
        check("ss_idle_c", {6'b0, busy}, 7'd0);

        // target=0 one-shot
        cyc("t0_start", 0,1,0,0, 0,0);
        idle("t0_wrap");
        check("t0_wrap_c", outs(), {1'b0, 4'd0, 1'b1, 1'b1});

        // terminal step coincident with stop
        cyc("ts_start", 0,1,0,0, 2,0);
        idle("ts1");
        idle("ts2");
        cyc("ts_stop", 0,0,1,0, 2,0);
        check("ts_stop_c", outs(), {1'b0, 4'd2, 1'b0, 1'b0});

        // reset mid-run at count=3
        cyc("rr_start", 0,1,0,1, 5,0);
        idle("rr1"); idle("rr2"); idle("rr3");
        check("rr_at3", {3'b0, count}, 7'd3);
        cyc("rr_reset", 1,1,0,1, 5,0);
        check("rr_reset_c", outs(), 7'd0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc("rand",
                ($urandom % 64) == 0,
                ($urandom % 8) == 0,
                ($urandom % 16) == 0,
                1'($urandom % 2),
                4'($urandom_range(0, 5)),
                4'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_sched_ctrl
